bram_tx: RTL and testbench
==========================

# bram_tx

CPU-to-AXI-stream transmit stage: the transmit-side counterpart of the receive buffer in the bram2udp path, sitting directly upstream of the UDP transmit engine. Software pushes 32-bit words one per register write into a 512-deep FIFO, programs a length word, then issues a start. The block streams exactly that frame out on an AXI4-Stream master with correct `tlast`/`tkeep`, and raises an interrupt on completion. Length encoding matches the receive side: `{word_count[11:0], last_tkeep[3:0]}`.

## Interface
Parameters:
- none; all constants live in the shared package.

Ports:
- `sclk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `tx_valid_i` in 1: one-cycle pulse; push `tx_data_i` into the FIFO.
- `tx_data_i` in 32: CPU data word.
- `WRLEN_reg_i` in 16: `[15:4]` word count (1..512), `[3:0]` `tkeep` for the last beat.
- `tx_start_i` in 1: one-cycle pulse; begin the frame.
- `tx_int_enable_i` in 1: enables `INT_tx_o` setting.
- `int_tx_clear_i` in 1: clears `INT_tx_o`.
- `tx_error_clear_i` in 1: clears `tx_error`.
- `INT_tx_o` out 1: frame-sent interrupt, sticky.
- `tx_error` out 1: sticky error flag.
- `tx_busy_o` out 1: high in every state except IDLE.
- `tx_level_o` out 10: FIFO occupancy in words, 0..512.
- `axi_tx_tvalid_o` out 1
- `axi_tx_tready_i` in 1
- `axi_tx_tdata_o` out 32
- `axi_tx_tkeep_o` out 4
- `axi_tx_tlast_o` out 1
- `axi_tx_tuser_o` out 64

## Operation
- **Reset values:** all outputs 0 (`tkeep` is 4'h0); FSM in IDLE; occupancy counter 0; internal FIFO reset asserted during `reset`.
- **Write path:**
  - A `tx_valid_i` in IDLE with `tx_level_o < 512` writes the word and increments occupancy.
  - A `tx_valid_i` while not in IDLE, or with the FIFO full, drops the word and sets `tx_error`.
- **Start (IDLE only):**
  - Latch `WRLEN_reg_i` into `len_q`.
  - If `len_q[15:4] == 0` or `len_q[15:4] > tx_level_o`: set `tx_error`, stay in IDLE, send nothing.
  - Otherwise go to PREFETCH.
  - `tx_start_i` outside IDLE: ignored, and `tx_error` is set.
- **FSM:**
  - IDLE → PREFETCH on a valid start.
  - PREFETCH (1 cycle): issue FIFO read, load the beat counter with the word count, then go to SEND.
  - SEND → DONE on the handshake of the last beat.
  - DONE (1 cycle) → IDLE.
- **Streaming:**
  - A 2-entry output skid buffer keeps FIFO reads ahead, so beats go back-to-back while `tready` is held high.
  - `tdata`, `tkeep`, `tlast` and `tuser` stay stable while `tvalid && !tready`.
  - `tkeep` is 4'hF on every beat except the last, which carries `len_q[3:0]`.
  - `tlast` is high only on beat N.
- **Arithmetic:**
  - The beat counter is 10 bits and decrements on each handshake.
  - `tlast` is asserted when the count equals 1.
  - Occupancy is decremented on each FIFO read; a simultaneous write and read cannot occur, because writes are blocked outside IDLE.
- **Completion:**
  - On the last-beat handshake, `INT_tx_o` is set if `tx_int_enable_i` is high.
  - In DONE, if the FIFO still holds words (more were written than the length), set `tx_error`, pulse the internal FIFO reset for one cycle, and zero occupancy.
- **Flag priority:** set wins over a clear in the same cycle, for both `INT_tx_o` and `tx_error`.
- **Reset mid-frame:** the frame is aborted, `tvalid` drops on the next cycle, and the FIFO is flushed. No partial `tlast` is generated.

## Timing
- Start pulse at cycle T: first `tvalid` at T+3 (T+1 PREFETCH, T+2 FIFO read data, T+3 presented).
- With `tready` tied high, an N-word frame finishes at T+2+N; `INT_tx_o` is high at T+3+N.
- FIFO read latency is 1 cycle; `tx_level_o` updates the cycle after a write or read strobe.
- `tx_busy_o` is high from T+1 through the DONE cycle.

## Configuration
- `BRAM_TX_TUSER_EN` defined: `axi_tx_tuser_o = {48'd0, len_q}`, held constant for every beat of the frame.
- `BRAM_TX_TUSER_EN` undefined: `axi_tx_tuser_o` is tied to 64'd0 and `len_q` is not routed to it.

## Structure
- Shared package holds:
  - FSM state enum: IDLE, PREFETCH, SEND, DONE.
  - `TX_FIFO_DEPTH` = 512.
  - Length field widths (12/4).
  - `TKEEP_FULL` = 4'hF.
- Sub-module: the existing `fifo_32x512`, instantiated as `tx_fifo`.
- The skid buffer is kept inline rather than as a separate module.

## Test plan
- Write 4 words (0xA0..0xA3), set WRLEN=0x0043, start with `tready` high → 4 beats on consecutive cycles, `tkeep` F/F/F/3, `tlast` on 0xA3, `INT_tx_o` high, `tx_error` low.
- Same frame with `tready` toggling 1-0-0-1… → data order unchanged and outputs stable during stalls; exactly 4 handshakes.
- WRLEN word count 5 with only 3 words in the FIFO, then start → `tx_error`=1, no `tvalid`, stays in IDLE with `tx_level_o`=3.
- Write 6 words, WRLEN=0x004F, start → 4 beats sent, then `tx_error`=1 in DONE and `tx_level_o`=0.
- Write 512 words plus one more, then start a 512-word frame → the 513th word is dropped with `tx_error`=1; beat 512 carries `tlast`.
- Assert `reset` after beat 2 of an 8-word frame → `tvalid`=0 next cycle, `tx_level_o`=0, IDLE; a new 1-word frame then sends correctly.

Source files
------------

// File: rtl/bram_tx_pkg.sv
// Shared constants and types for the bram_tx transmit stage.
package bram_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_SEND     = 2'd2,
    ST_DONE     = 2'd3
  } tx_state_e;

  localparam int TX_FIFO_DEPTH = 512;
  localparam int FIFO_AW       = $clog2(TX_FIFO_DEPTH);
  localparam int LEVEL_W       = FIFO_AW + 1;

  // Length word layout: {word_count, last_tkeep}
  localparam int LEN_WORDS_W = 12;
  localparam int LEN_KEEP_W  = 4;
  localparam int LEN_W       = LEN_WORDS_W + LEN_KEEP_W;

  localparam logic [LEN_KEEP_W-1:0] TKEEP_FULL = 4'hF;
  localparam logic [LEVEL_W-1:0]    LEVEL_FULL = LEVEL_W'(TX_FIFO_DEPTH);

endpackage

// File: rtl/fifo_32x512.sv
// 32-bit x 512-entry FIFO storage with registered (1-cycle) read data.
// Occupancy is tracked by the caller, which never writes when full or
// reads when empty.
module fifo_32x512
  import bram_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  output logic [31:0] rd_data_o
);

  logic [31:0]        mem_q [TX_FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [31:0]        rd_data_q;

  // Storage write port.
  // NOTE: the array has no reset so it maps onto block RAM; pointers alone define contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and registered read data; reset empties the FIFO.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bram_tx.sv
// CPU-to-AXI-stream transmit stage: words are pushed into a 512-deep FIFO,
// a length word is programmed, and a start streams the frame with
// tlast/tkeep and a completion interrupt.
// Optional feature: define BRAM_TX_TUSER_EN to drive the latched length on tuser.
module bram_tx
  import bram_tx_pkg::*;
(
  input  logic               sclk,
  input  logic               reset,
  input  logic               tx_valid_i,
  input  logic [31:0]        tx_data_i,
  input  logic [LEN_W-1:0]   WRLEN_reg_i,
  input  logic               tx_start_i,
  input  logic               tx_int_enable_i,
  input  logic               int_tx_clear_i,
  input  logic               tx_error_clear_i,
  output logic               INT_tx_o,
  output logic               tx_error,
  output logic               tx_busy_o,
  output logic [LEVEL_W-1:0] tx_level_o,
  output logic               axi_tx_tvalid_o,
  input  logic               axi_tx_tready_i,
  output logic [31:0]        axi_tx_tdata_o,
  output logic [3:0]         axi_tx_tkeep_o,
  output logic               axi_tx_tlast_o,
  output logic [63:0]        axi_tx_tuser_o
);

  tx_state_e              state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [9:0]             beat_cnt_q, beat_cnt_d;
  logic [LEN_WORDS_W-1:0] rd_left_q, rd_left_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   pend_q, pend_d;       // FIFO read data valid this cycle
  logic [31:0]            skid_q [2];
  logic [31:0]            skid_d [2];
  logic [1:0]             occ_q, occ_d;         // skid entries held, 0..2
  logic                   int_q, int_d;
  logic                   err_q, err_d;

  logic                   fifo_rd_en, flush;
  logic [31:0]            fifo_rd_data;

  // Control decode
  logic [LEN_WORDS_W-1:0] start_words;
  logic                   in_idle, start_ok, wr_ok;
  logic                   tvalid, pop, last_hs, wr_slot;
  logic [1:0]             inflight;

  assign start_words = WRLEN_reg_i[LEN_W-1:LEN_KEEP_W];
  assign in_idle     = (state_q == ST_IDLE);
  assign start_ok    = in_idle && tx_start_i && (start_words != '0) &&
                       (start_words <= LEN_WORDS_W'(level_q));
  assign wr_ok       = tx_valid_i && in_idle && (level_q != LEVEL_FULL);
  assign tvalid      = (occ_q != 2'd0);
  assign pop         = tvalid && axi_tx_tready_i;
  assign last_hs     = pop && (beat_cnt_q == 10'd1);
  assign inflight    = occ_q + {1'b0, pend_q};
  // Landing slot for returning read data, after this cycle's pop.
  assign wr_slot     = pop ? (occ_q == 2'd2) : (occ_q != 2'd0);

  fifo_32x512 tx_fifo (
    .clk_i     (sclk),
    .rst_i     (reset | flush),
    .wr_en_i   (wr_ok),
    .wr_data_i (tx_data_i),
    .rd_en_i   (fifo_rd_en),
    .rd_data_o (fifo_rd_data)
  );

  // FSM state register.
  always_ff @(posedge sclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_ok) state_d = ST_PREFETCH;
      ST_PREFETCH: state_d = ST_SEND;
      ST_SEND:     if (last_hs) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO read strobe (kept ahead of the skid) and leftover flush.
  always_comb begin
    fifo_rd_en = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_PREFETCH: fifo_rd_en = 1'b1;
      ST_SEND:     fifo_rd_en = (rd_left_q != '0) && ((inflight < 2'd2) || pop);
      ST_DONE:     flush      = (level_q != '0);
      default:     ;
    endcase
  end

  // Datapath next-state: length latch, counters, skid buffer, sticky flags.
  always_comb begin
    len_d      = len_q;
    rd_left_d  = rd_left_q;
    beat_cnt_d = beat_cnt_q;
    level_d    = level_q;
    pend_d     = fifo_rd_en;
    skid_d     = skid_q;
    occ_d      = occ_q - {1'b0, pop} + {1'b0, pend_q};
    int_d      = int_q;
    err_d      = err_q;

    if (in_idle && tx_start_i) len_d = WRLEN_reg_i;

    if (state_q == ST_PREFETCH) begin
      rd_left_d  = len_q[LEN_W-1:LEN_KEEP_W] - 1'b1;
      beat_cnt_d = len_q[LEN_KEEP_W+9:LEN_KEEP_W];
    end else begin
      if (fifo_rd_en) rd_left_d  = rd_left_q - 1'b1;
      if (pop)        beat_cnt_d = beat_cnt_q - 1'b1;
    end

    if (flush)           level_d = '0;
    else if (wr_ok)      level_d = level_q + 1'b1;
    else if (fifo_rd_en) level_d = level_q - 1'b1;

    if (pop)    skid_d[0]       = skid_q[1];
    if (pend_q) skid_d[wr_slot] = fifo_rd_data;

    // Clears first so a same-cycle set wins.
    if (int_tx_clear_i)              int_d = 1'b0;
    if (last_hs && tx_int_enable_i)  int_d = 1'b1;
    if (tx_error_clear_i)            err_d = 1'b0;
    if ((tx_valid_i && !wr_ok) || (tx_start_i && !start_ok) || flush) err_d = 1'b1;
  end

  // Datapath registers; reset aborts any frame in flight.
  always_ff @(posedge sclk) begin
    if (reset) begin
      len_q      <= '0;
      rd_left_q  <= '0;
      beat_cnt_q <= '0;
      level_q    <= '0;
      pend_q     <= 1'b0;
      skid_q     <= '{default: '0};
      occ_q      <= 2'd0;
      int_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      rd_left_q  <= rd_left_d;
      beat_cnt_q <= beat_cnt_d;
      level_q    <= level_d;
      pend_q     <= pend_d;
      skid_q     <= skid_d;
      occ_q      <= occ_d;
      int_q      <= int_d;
      err_q      <= err_d;
    end
  end

  assign INT_tx_o        = int_q;
  assign tx_error        = err_q;
  assign tx_busy_o       = !in_idle;
  assign tx_level_o      = level_q;
  assign axi_tx_tvalid_o = tvalid;
  assign axi_tx_tdata_o  = skid_q[0];
  assign axi_tx_tlast_o  = tvalid && (beat_cnt_q == 10'd1);
  assign axi_tx_tkeep_o  = !tvalid        ? 4'h0 :
                           axi_tx_tlast_o ? len_q[LEN_KEEP_W-1:0] : TKEEP_FULL;

`ifdef BRAM_TX_TUSER_EN
  assign axi_tx_tuser_o = {48'd0, len_q};
`else
  assign axi_tx_tuser_o = 64'd0;
`endif

endmodule

// File: tb/tb_bram_tx.sv
// Scoreboard bench for bram_tx: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares on every AXI handshake.
module tb_bram_tx;

  logic        sclk = 1'b0;
  logic        reset;
  logic        tx_valid_i;
  logic [31:0] tx_data_i;
  logic [15:0] WRLEN_reg_i;
  logic        tx_start_i;
  logic        tx_int_enable_i;
  logic        int_tx_clear_i;
  logic        tx_error_clear_i;
  logic        INT_tx_o;
  logic        tx_error;
  logic        tx_busy_o;
  logic [9:0]  tx_level_o;
  logic        axi_tx_tvalid_o;
  logic        axi_tx_tready_i;
  logic [31:0] axi_tx_tdata_o;
  logic [3:0]  axi_tx_tkeep_o;
  logic        axi_tx_tlast_o;
  logic [63:0] axi_tx_tuser_o;

  bram_tx dut (
    .sclk             (sclk),
    .reset            (reset),
    .tx_valid_i       (tx_valid_i),
    .tx_data_i        (tx_data_i),
    .WRLEN_reg_i      (WRLEN_reg_i),
    .tx_start_i       (tx_start_i),
    .tx_int_enable_i  (tx_int_enable_i),
    .int_tx_clear_i   (int_tx_clear_i),
    .tx_error_clear_i (tx_error_clear_i),
    .INT_tx_o         (INT_tx_o),
    .tx_error         (tx_error),
    .tx_busy_o        (tx_busy_o),
    .tx_level_o       (tx_level_o),
    .axi_tx_tvalid_o  (axi_tx_tvalid_o),
    .axi_tx_tready_i  (axi_tx_tready_i),
    .axi_tx_tdata_o   (axi_tx_tdata_o),
    .axi_tx_tkeep_o   (axi_tx_tkeep_o),
    .axi_tx_tlast_o   (axi_tx_tlast_o),
    .axi_tx_tuser_o   (axi_tx_tuser_o)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [63:0] user;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cyc[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ready_mode = 0;   // 0: high, 1: 1-0-0 pattern, 2: low
  int    pat = 0;

  always @(posedge sclk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_user(input logic [15:0] len);
`ifdef BRAM_TX_TUSER_EN
    return {48'd0, len};
`else
    return 64'd0 & {48'd0, len};
`endif
  endfunction

  // Ready driver, applied a little after each rising edge.
  initial begin
    axi_tx_tready_i = 1'b0;
    forever begin
      @(posedge sclk);
      #2;
      case (ready_mode)
        0:       axi_tx_tready_i = 1'b1;
        1:       begin axi_tx_tready_i = (pat % 3 == 0); pat++; end
        default: axi_tx_tready_i = 1'b0;
      endcase
    end
  end

  // Monitor: handshakes pop the scoreboard; stalled beats must hold.
  logic        stall_q = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_keep;
  logic        held_last;
  logic [63:0] held_user;

  always @(negedge sclk) begin
    beat_t e;
    if (stall_q) begin
      check("stall_tvalid", axi_tx_tvalid_o, 1'b1);
      check("stall_tdata",  axi_tx_tdata_o,  held_data);
      check("stall_tkeep",  axi_tx_tkeep_o,  held_keep);
      check("stall_tlast",  axi_tx_tlast_o,  held_last);
      check("stall_tuser",  axi_tx_tuser_o,  held_user);
    end
    stall_q = 1'b0;
    if (!reset && axi_tx_tvalid_o && !axi_tx_tready_i) begin
      stall_q   = 1'b1;
      held_data = axi_tx_tdata_o;
      held_keep = axi_tx_tkeep_o;
      held_last = axi_tx_tlast_o;
      held_user = axi_tx_tuser_o;
    end
    if (!reset && axi_tx_tvalid_o && axi_tx_tready_i) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", axi_tx_tdata_o);
      end else begin
        e = exp_q.pop_front();
        check("beat_tdata", axi_tx_tdata_o, e.data);
        check("beat_tkeep", axi_tx_tkeep_o, e.keep);
        check("beat_tlast", axi_tx_tlast_o, e.last);
        check("beat_tuser", axi_tx_tuser_o, e.user);
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic start(input logic [15:0] len, output int t0);
    WRLEN_reg_i = len;
    tx_start_i  = 1'b1;
    t0          = cyc;
    tick();
    tx_start_i  = 1'b0;
  endtask

  // Expect words base..base+n-1, last beat carrying the length's keep field.
  task automatic expect_frame(input logic [31:0] base, input int n, input logic [15:0] len);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.last = (i == n - 1);
      b.keep = b.last ? len[3:0] : 4'hF;
      b.user = exp_user(len);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (tx_busy_o && k < budget) begin
      tick();
      k++;
    end
    check("idle_reached", tx_busy_o, 1'b0);
  endtask

  task automatic pulse_clear(input logic clr_int, input logic clr_err);
    int_tx_clear_i   = clr_int;
    tx_error_clear_i = clr_err;
    tick();
    int_tx_clear_i   = 1'b0;
    tx_error_clear_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    beat_t b;
    reset            = 1'b1;
    tx_valid_i       = 1'b0;
    tx_data_i        = '0;
    WRLEN_reg_i      = '0;
    tx_start_i       = 1'b0;
    tx_int_enable_i  = 1'b1;
    int_tx_clear_i   = 1'b0;
    tx_error_clear_i = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_tvalid", axi_tx_tvalid_o, 1'b0);
    check("rst_tdata",  axi_tx_tdata_o,  32'd0);
    check("rst_tkeep",  axi_tx_tkeep_o,  4'h0);
    check("rst_tlast",  axi_tx_tlast_o,  1'b0);
    check("rst_tuser",  axi_tx_tuser_o,  64'd0);
    check("rst_int",    INT_tx_o,        1'b0);
    check("rst_err",    tx_error,        1'b0);
    check("rst_busy",   tx_busy_o,       1'b0);
    check("rst_level",  tx_level_o,      10'd0);

    // 4-word frame, tready high: back-to-back beats at T+3..T+6
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    check("t1_level", tx_level_o, 10'd4);
    expect_frame(32'hA0, 4, 16'h0043);
    hs_cyc.delete();
    start(16'h0043, t0);
    wait_idle(50);
    check("t1_int", INT_tx_o, 1'b1);
    check("t1_err", tx_error, 1'b0);
    check("t1_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) begin
      check("t1_first_beat_cycle", hs_cyc[0], t0 + 3);
      check("t1_last_beat_cycle",  hs_cyc[3], t0 + 6);
    end
    pulse_clear(1'b1, 1'b0);
    check("t1_int_cleared", INT_tx_o, 1'b0);

    // Same frame with tready stalling 1-0-0
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    expect_frame(32'hA0, 4, 16'h0043);
    hs_cyc.delete();
    pat = 0;
    ready_mode = 1;
    start(16'h0043, t0);
    wait_idle(100);
    ready_mode = 0;
    check("t2_beats", hs_cyc.size(), 4);
    check("t2_int", INT_tx_o, 1'b1);
    pulse_clear(1'b1, 1'b0);

    // Length 5 with only 3 words: rejected
    for (int i = 0; i < 3; i++) push_word(32'h30 + 32'(i));
    start(16'h005F, t0);
    check("t3_err",   tx_error,   1'b1);
    check("t3_busy",  tx_busy_o,  1'b0);
    repeat (4) tick();
    check("t3_tvalid", axi_tx_tvalid_o, 1'b0);
    check("t3_level",  tx_level_o, 10'd3);
    pulse_clear(1'b0, 1'b1);
    check("t3_err_cleared", tx_error, 1'b0);
    expect_frame(32'h30, 3, 16'h003F);
    start(16'h003F, t0);
    wait_idle(50);
    check("t3b_err",   tx_error,   1'b0);
    check("t3b_level", tx_level_o, 10'd0);
    pulse_clear(1'b1, 1'b0);

    // Zero-length start with simultaneous error clear: set wins
    WRLEN_reg_i      = 16'h000F;
    tx_start_i       = 1'b1;
    tx_error_clear_i = 1'b1;
    tick();
    tx_start_i       = 1'b0;
    tx_error_clear_i = 1'b0;
    check("prio_err_set_wins", tx_error, 1'b1);
    check("prio_busy", tx_busy_o, 1'b0);
    pulse_clear(1'b0, 1'b1);
    check("prio_err_cleared", tx_error, 1'b0);

    // 6 words, 4-word frame, interrupt disabled: leftover flushed in DONE
    tx_int_enable_i = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'hB0 + 32'(i));
    expect_frame(32'hB0, 4, 16'h004F);
    start(16'h004F, t0);
    wait_idle(50);
    check("t4_err",   tx_error,   1'b1);
    check("t4_level", tx_level_o, 10'd0);
    check("t4_int_disabled", INT_tx_o, 1'b0);
    tx_int_enable_i = 1'b1;
    pulse_clear(1'b0, 1'b1);

    // Fill to 512, 513th dropped, then a full-depth frame
    for (int i = 0; i < 512; i++) push_word(32'h5000_0000 + 32'(i));
    check("t5_level_full", tx_level_o, 10'd512);
    check("t5_err_before", tx_error, 1'b0);
    push_word(32'hDEAD_BEEF);
    check("t5_err_overflow", tx_error, 1'b1);
    check("t5_level_held",   tx_level_o, 10'd512);
    expect_frame(32'h5000_0000, 512, 16'h200F);
    hs_cyc.delete();
    start(16'h200F, t0);
    wait_idle(2000);
    check("t5_beats", hs_cyc.size(), 512);
    check("t5_level", tx_level_o, 10'd0);
    check("t5_int",   INT_tx_o,   1'b1);
    pulse_clear(1'b1, 1'b1);

    // Reset after beat 2 of an 8-word frame
    for (int i = 0; i < 8; i++) push_word(32'hC0 + 32'(i));
    for (int i = 0; i < 2; i++) begin
      b.data = 32'hC0 + 32'(i);
      b.keep = 4'hF;
      b.last = 1'b0;
      b.user = exp_user(16'h008F);
      exp_q.push_back(b);
    end
    hs_cyc.delete();
    start(16'h008F, t0);
    k = 0;
    while (hs_cyc.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    check("t6_two_beats", hs_cyc.size(), 2);
    ready_mode = 2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_tvalid", axi_tx_tvalid_o, 1'b0);
    check("t6_level",  tx_level_o, 10'd0);
    check("t6_busy",   tx_busy_o,  1'b0);
    check("t6_sb_empty", exp_q.size(), 0);
    ready_mode = 0;
    tick();
    push_word(32'hD0);
    expect_frame(32'hD0, 1, 16'h0012);
    hs_cyc.delete();
    start(16'h0012, t0);
    wait_idle(50);
    check("t6_new_beats", hs_cyc.size(), 1);
    check("t6_new_int",   INT_tx_o, 1'b1);
    check("t6_new_err",   tx_error, 1'b0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
